tetris_input_ctrl: RTL and testbench

//   Conditions the four raw Basys3 pushbuttons into the single-cycle move strobes consumed
//   by tetris_logic (down, left, right, rotate). Per button: 2-FF synchronizer, counter

---
 rtl/tetris_input_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_tetris_input_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_input_ctrl.sv
// Pushbutton conditioner for the Tetris game FSM: 2-FF sync, counter debounce and rise detect per button.
// Define TETRIS_INPUT_REPEAT_EN to build hold-to-repeat on down/left/right; otherwise every button fires once per press.
module tetris_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic gm_clk,
  input  logic gm_rst_n,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_rotate,
  output logic down,
  output logic left,
  output logic right,
  output logic rotate
);

  localparam int NB = 4;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if ((DEBOUNCE_CYCLES < 1) || (REPEAT_DELAY < 2) || (REPEAT_PERIOD < 1)) begin : g_bad_params
    $error("tetris_input_ctrl: illegal timing parameters");
  end

  // Bit order everywhere: 0 down, 1 left, 2 right, 3 rotate
  logic [NB-1:0] btn_s;
  logic [NB-1:0] sync1_r;
  logic [NB-1:0] sync2_r;
  logic [NB-1:0] stable_r;
  logic [NB-1:0] stable_nxt_s;
  logic [NB-1:0] flip_s;
  logic [NB-1:0] rise_s;
  logic [NB-1:0] strobe_s;
  logic [2:0]    pulse_s;
  logic [CW-1:0] cnt_r [NB];

  assign btn_s = {btn_rotate, btn_right, btn_left, btn_down};

  // Two-flop synchronizer for the asynchronous pushbuttons
  always_ff @(posedge gm_clk or negedge gm_rst_n) begin
    if (!gm_rst_n) begin
      sync1_r <= {NB{1'b0}};
      sync2_r <= {NB{1'b0}};
    end else begin
      sync1_r <= btn_s;
      sync2_r <= sync1_r;
    end
  end

  // A button flips only after disagreeing with its stable level for DEBOUNCE_CYCLES edges
  always_comb begin
    flip_s = {NB{1'b0}};
    for (int i = 0; i < NB; i++) begin
      if ((sync2_r[i] != stable_r[i]) && (cnt_r[i] == CNT_LAST)) begin
        flip_s[i] = 1'b1;
      end else begin
        flip_s[i] = 1'b0;
      end
    end
    stable_nxt_s = stable_r ^ flip_s;
    rise_s       = flip_s & sync2_r;
  end

  // Debounce counters and stable levels
  always_ff @(posedge gm_clk or negedge gm_rst_n) begin
    if (!gm_rst_n) begin
      stable_r <= {NB{1'b0}};
      for (int i = 0; i < NB; i++) begin
        cnt_r[i] <= {CW{1'b0}};
      end
    end else begin
      stable_r <= stable_nxt_s;
      for (int i = 0; i < NB; i++) begin
        if ((sync2_r[i] == stable_r[i]) || flip_s[i]) begin
          cnt_r[i] <= {CW{1'b0}};
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

`ifdef TETRIS_INPUT_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(RMAX + 1);
  localparam logic [TW-1:0] T_DELAY  = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [TW-1:0] T_ZERO   = TW'(0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  rep_state_e    state_r     [3];
  rep_state_e    state_nxt_s [3];
  logic [TW-1:0] timer_r     [3];
  logic [TW-1:0] timer_nxt_s [3];

  // Repeat schedule: first pulse on press, then after REPEAT_DELAY, then every REPEAT_PERIOD
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_nxt_s[i] = state_r[i];
      timer_nxt_s[i] = timer_r[i];
      pulse_s[i]     = 1'b0;
      case (state_r[i])
        ST_IDLE: begin
          if (rise_s[i]) begin
            pulse_s[i]     = 1'b1;
            timer_nxt_s[i] = T_ONE;
            state_nxt_s[i] = ST_DELAY;
          end else begin
            state_nxt_s[i] = ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (!stable_r[i]) begin
            timer_nxt_s[i] = T_ZERO;
            state_nxt_s[i] = ST_IDLE;
          end else if (timer_r[i] == T_DELAY) begin
            pulse_s[i]     = 1'b1;
            timer_nxt_s[i] = T_ONE;
            state_nxt_s[i] = ST_REPEAT;
          end else begin
            timer_nxt_s[i] = timer_r[i] + T_ONE;
          end
        end
        ST_REPEAT: begin
          if (!stable_r[i]) begin
            timer_nxt_s[i] = T_ZERO;
            state_nxt_s[i] = ST_IDLE;
          end else if (timer_r[i] == T_PERIOD) begin
            pulse_s[i]     = 1'b1;
            timer_nxt_s[i] = T_ONE;
          end else begin
            timer_nxt_s[i] = timer_r[i] + T_ONE;
          end
        end
        default: begin
          timer_nxt_s[i] = T_ZERO;
          state_nxt_s[i] = ST_IDLE;
        end
      endcase
    end
  end

  // Repeat state and timer registers
  always_ff @(posedge gm_clk or negedge gm_rst_n) begin
    if (!gm_rst_n) begin
      for (int i = 0; i < 3; i++) begin
        state_r[i] <= ST_IDLE;
        timer_r[i] <= T_ZERO;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_r[i] <= state_nxt_s[i];
        timer_r[i] <= timer_nxt_s[i];
      end
    end
  end
`else
  assign pulse_s = rise_s[2:0];
`endif

  // Left and right cancel each other while both are debounced-pressed
  always_comb begin
    strobe_s[0] = pulse_s[0];
    strobe_s[1] = pulse_s[1] & ~(stable_nxt_s[1] & stable_nxt_s[2]);
    strobe_s[2] = pulse_s[2] & ~(stable_nxt_s[1] & stable_nxt_s[2]);
    strobe_s[3] = rise_s[3];
  end

  // Registered strobe outputs
  always_ff @(posedge gm_clk or negedge gm_rst_n) begin
    if (!gm_rst_n) begin
      down   <= 1'b0;
      left   <= 1'b0;
      right  <= 1'b0;
      rotate <= 1'b0;
    end else begin
      down   <= strobe_s[0];
      left   <= strobe_s[1];
      right  <= strobe_s[2];
      rotate <= strobe_s[3];
    end
  end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Self-checking bench for tetris_input_ctrl: behavioural model compared every cycle, plus directed literal checks.
// Honours TETRIS_INPUT_REPEAT_EN the same way the design does.
module tb_tetris_input_ctrl;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       down, left, right, rotate;
  logic [3:0] outs;

  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .gm_clk(clk),
    .gm_rst_n(rst_n),
    .btn_down(btn[0]),
    .btn_left(btn[1]),
    .btn_right(btn[2]),
    .btn_rotate(btn[3]),
    .down(down),
    .left(left),
    .right(right),
    .rotate(rotate)
  );

  assign outs = {rotate, right, left, down};

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    slog [4][$];
  string nm [4] = '{"down", "left", "right", "rotate"};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  // Behavioural model: delayed sample, D-wide agreement window, arithmetic repeat schedule
  bit d1 [4], d2 [4], st [4], held [4], exp_o [4], pulse [4];
  bit win [4][D];
  bit seen, all_diff, rise;
  int press [4];
  int delta;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        d1[i] = 1'b0; d2[i] = 1'b0; st[i] = 1'b0; held[i] = 1'b0; exp_o[i] = 1'b0;
        for (int k = 0; k < D; k++) win[i][k] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        seen  = d2[i];
        d2[i] = d1[i];
        d1[i] = btn[i];
        for (int k = D - 1; k > 0; k--) win[i][k] = win[i][k-1];
        win[i][0] = seen;
        all_diff = 1'b1;
        for (int k = 0; k < D; k++) if (win[i][k] == st[i]) all_diff = 1'b0;
        rise = all_diff && seen;
        pulse[i] = rise;
`ifdef TETRIS_INPUT_REPEAT_EN
        if (i < 3) begin
          if (held[i] && !st[i]) held[i] = 1'b0;
          if (held[i]) begin
            delta = cyc - press[i];
            if (delta == RD || (delta > RD && (delta - RD) % RP == 0)) pulse[i] = 1'b1;
          end
          if (rise) begin
            held[i]  = 1'b1;
            press[i] = cyc;
          end
        end
`endif
        if (all_diff) st[i] = !st[i];
      end
      exp_o[0] = pulse[0];
      exp_o[1] = pulse[1] && !(st[1] && st[2]);
      exp_o[2] = pulse[2] && !(st[1] && st[2]);
      exp_o[3] = pulse[3];
    end
  end

  // Cycle-by-cycle compare against the model, and strobe logging for directed checks
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      check(nm[i], {31'd0, outs[i]}, {31'd0, exp_o[i]});
      if (outs[i] === 1'b1) slog[i].push_back(cyc);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    btn = 4'b0000;
    cycles(15);
    for (int i = 0; i < 4; i++) slog[i].delete();
  endtask

  function automatic int first_of(input int i);
    if (slog[i].size() == 0) return -1;
    else return slog[i][0];
  endfunction

  int c0, c1, nexp;
  int rem [4];

  initial begin
    // Reset state
    cycles(3);
    for (int i = 0; i < 4; i++) check({"reset_", nm[i]}, {31'd0, outs[i]}, 32'd0);
    rst_n = 1'b1;
    settle();

    // Short left glitch is rejected
    btn = 4'b0010;
    cycles(3);
    btn = 4'b0000;
    cycles(15);
    for (int i = 0; i < 4; i++) check({"glitch_cnt_", nm[i]}, slog[i].size(), 32'd0);
    settle();

    // Rotate held 50 cycles: one strobe after edge 6, none on release
    c0 = cyc;
    btn = 4'b1000;
    cycles(50);
    btn = 4'b0000;
    cycles(20);
    check("rot_cnt", slog[3].size(), 32'd1);
    check("rot_at", first_of(3), c0 + 6);
    settle();

    // Right held 41 cycles: repeat schedule T, T+10, T+13, ...
    c0 = cyc;
    btn = 4'b0100;
    cycles(41);
    btn = 4'b0000;
    cycles(20);
`ifdef TETRIS_INPUT_REPEAT_EN
    nexp = 12;
`else
    nexp = 1;
`endif
    check("rpt_cnt", slog[2].size(), nexp);
    check("rpt_first", first_of(2), c0 + 6);
    for (int j = 1; j < nexp && j < slog[2].size(); j++)
      check("rpt_tick", slog[2][j], c0 + 16 + 3 * (j - 1));
    settle();

    // Left+right conflict, then drop right
    c0 = cyc;
    btn = 4'b0110;
    cycles(30);
    btn = 4'b0010;
    cycles(15);
    btn = 4'b0000;
    cycles(20);
    check("conf_right_cnt", slog[2].size(), 32'd0);
`ifdef TETRIS_INPUT_REPEAT_EN
    check("conf_left_first", first_of(1), c0 + 37);
`else
    check("conf_left_cnt", slog[1].size(), 32'd0);
`endif
    settle();

    // Reset mid-repeat with down held
    btn = 4'b0001;
    cycles(25);
`ifdef TETRIS_INPUT_REPEAT_EN
    check("pre_rst_down", {31'd0, down}, 32'd1);
`endif
    rst_n = 1'b0;
    #1;
    check("rst_down_now", {31'd0, down}, 32'd0);
    cycles(3);
    rst_n = 1'b1;
    c1 = cyc;
    for (int i = 0; i < 4; i++) slog[i].delete();
    cycles(30);
    btn = 4'b0000;
    cycles(20);
    check("rst_down_first", first_of(0), c1 + 6);
`ifdef TETRIS_INPUT_REPEAT_EN
    if (slog[0].size() > 1) check("rst_down_second", slog[0][1], c1 + 16);
    else check("rst_down_second_cnt", slog[0].size(), 32'd2);
`else
    check("rst_down_cnt", slog[0].size(), 32'd1);
`endif
    settle();

    // Down and rotate on the same edge
    c0 = cyc;
    btn = 4'b1001;
    cycles(8);
    btn = 4'b0000;
    cycles(20);
    check("dr_down_at", first_of(0), c0 + 6);
    check("dr_rot_at", first_of(3), c0 + 6);
    check("dr_rot_cnt", slog[3].size(), 32'd1);
    settle();

    // Random presses, glitches and occasional resets against the model
    for (int i = 0; i < 4; i++) rem[i] = 0;
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (rem[i] == 0) begin
          btn[i] = 1'($urandom_range(0, 1));
          rem[i] = $urandom_range(1, 40);
        end else begin
          rem[i] = rem[i] - 1;
        end
      end
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
      end
    end
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
